patch_netlist_evaluator: RTL
============================

Name: patch_netlist_evaluator

Overview:
- Consumer side of the gate-level patch netlists this team emits. A netlist writer produces a sequence of gate records (not/and/or over primary inputs and internal wires, ending in one output wire). This block reads that record stream over a valid/ready interface and evaluates it for one primary-input vector.
- It returns the patch output value and checks stream legality (use-before-define, multiple drivers, illegal opcodes).
- It sits between the on-chip patch loader and the rectified logic, and also serves as a self-check engine for patch streams.

Parameters:
- PI_W, 3, number of primary inputs; they occupy node IDs 0..PI_W-1.
- ID_W, 9, node ID width; MAX_NODES = 2**ID_W.
- CNT_W, 10, width of gate_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins evaluation of a new stream.
- pi_vec  in  PI_W  primary-input values, sampled on start; bit i drives node i.
- rec_valid  in  1  record present.
- rec_ready  out  1  block accepts the record this cycle.
- rec_op  in  3  0=NOT(a), 1=AND(a,b), 2=OR(a,b), 3=BUF(a), 7=END(a); 4-6 illegal.
- rec_dst  in  ID_W  destination node; ignored for END.
- rec_a  in  ID_W  source A.
- rec_b  in  ID_W  source B; ignored for NOT, BUF and END.
- busy  out  1  high in RUN.
- done  out  1  high in DONE, held.
- result  out  1  value of the END source node; valid while done=1.
- err  out  1  high in ERR, held.
- err_code  out  2  1=undefined source, 2=illegal dst (PI range or already driven), 3=illegal opcode.
- gate_count  out  CNT_W  accepted gate records (END excluded); saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE.
  - Outputs: rec_ready=0, busy=0, done=0, result=0, err=0, err_code=0, gate_count=0.
  - Value array and defined bitmap cleared.
- Storage: val[MAX_NODES] and def[MAX_NODES], one flop each.
- State machine: IDLE, RUN, DONE, ERR.
- IDLE/DONE/ERR with start=1:
  - Next cycle the state is RUN; def cleared.
  - For nodes 0..PI_W-1: def set and val loaded from pi_vec.
  - gate_count, done, err, err_code and result cleared.
- RUN:
  - rec_ready=1 combinationally whenever state is RUN.
  - A record is accepted on a cycle with rec_valid=1 and rec_ready=1. Throughput is one record per cycle, and the write lands at the end of the accepting cycle.
  - The next record may source the node just written.
- Checks on an accepted record, in priority order:
  1. Illegal opcode -> code 3.
  2. Any used source with def=0 -> code 1. A self-reference (src==dst, undefined) also gives code 1.
  3. For gate ops, dst<PI_W or def[dst]=1 -> code 2.
- On any failed check: no write, gate_count unchanged, next state ERR.
- Gate op passing all checks: val[dst] and def[dst] written; gate_count increments, saturating.
- END passing all checks: result <= val[a]; next state DONE.
- start while in RUN is ignored.
- DONE: rec_ready=0, done=1, result held until the next start.
- ERR: rec_ready=0, err=1, err_code held until the next start. result stays 0.
- Latency: result and done are visible the cycle after END is accepted, i.e. one register stage.
- Reset asserted mid-stream aborts immediately to the reset values. A record in flight is dropped.
- rec_valid in IDLE/DONE/ERR is never accepted; the upstream holds its record.

Test Plan:
- Basic eval, nodes 0=g1, 1=g5, 2=n29:
  - pi_vec=3'b100, then records NOT(3,a=2), OR(4,a=0,b=1), AND(5,a=3,b=4), END(a=5) -> done=1, result=0, gate_count=3, err=0.
  - Same stream with pi_vec=3'b010 -> result=1.
- Backpressure: rec_valid toggled 1/0 every cycle over a 6-gate stream -> same result as the continuous stream; gate_count=6; no record lost or duplicated.
- Use-before-define: AND(3,a=0,b=7) with node 7 undefined -> err=1, err_code=1, gate_count=0, rec_ready=0 the next cycle.
- Illegal dst and opcode:
  - OR(1,a=0,b=2) -> err_code=2.
  - Redriving node 3 after NOT(3,2) -> err_code=2, gate_count=1.
  - op=5 -> err_code=3.
- Restart and reset:
  - start during RUN ignored.
  - start from DONE clears done and gate_count, then re-evaluates with the new pi_vec.
  - rst_n low mid-stream -> all outputs 0 the same cycle; rec_ready=0.
- Saturation: CNT_W=4 with 20 gates -> gate_count=15, correct result.

Source files
------------

// File: rtl/patch_netlist_evaluator.sv
// patch_netlist_evaluator
// Reads a stream of gate records (NOT/AND/OR/BUF, closed by END) over a
// valid/ready link and evaluates the patch netlist for one primary-input
// vector. It also checks the stream for legal opcodes, sources that are
// defined before use, and single drivers.
module patch_netlist_evaluator #(
    parameter int PI_W  = 3,
    parameter int ID_W  = 9,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PI_W-1:0]  pi_vec,
    input  logic             rec_valid,
    output logic             rec_ready,
    input  logic [2:0]       rec_op,
    input  logic [ID_W-1:0]  rec_dst,
    input  logic [ID_W-1:0]  rec_a,
    input  logic [ID_W-1:0]  rec_b,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] gate_count
);

    localparam int MAX_NODES = 2 ** ID_W;

    localparam logic [2:0] OP_NOT = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_BUF = 3'd3;
    localparam logic [2:0] OP_END = 3'd7;

    localparam logic [1:0] CODE_OK     = 2'd0;
    localparam logic [1:0] CODE_UNDEF  = 2'd1;
    localparam logic [1:0] CODE_BADDST = 2'd2;
    localparam logic [1:0] CODE_BADOP  = 2'd3;

    // Node IDs below this value are primary inputs and can never be driven.
    localparam logic [ID_W-1:0]      PI_LIMIT = ID_W'(PI_W);
    localparam logic [MAX_NODES-1:0] PI_MASK  =
        {{(MAX_NODES-PI_W){1'b0}}, {PI_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [MAX_NODES-1:0] r_val;
    logic [MAX_NODES-1:0] r_def;
    logic                 r_result;
    logic [1:0]           r_err_code;
    logic [CNT_W-1:0]     r_gate_count;

    logic       w_accept;
    logic       w_restart;
    logic       w_op_gate;
    logic       w_op_end;
    logic       w_op_two;
    logic       w_src_undef;
    logic       w_dst_bad;
    logic [1:0] w_code;
    logic       w_gate_val;

    // Record decode and legality terms; all purely combinational on the record.
    assign w_accept    = rec_valid && (r_state == S_RUN);
    assign w_restart   = start && (r_state != S_RUN);
    assign w_op_gate   = (rec_op <= OP_BUF);
    assign w_op_end    = (rec_op == OP_END);
    assign w_op_two    = (rec_op == OP_AND) || (rec_op == OP_OR);
    // A self-referencing gate reads its own, still undefined, destination,
    // so it falls out here as an undefined source without a special case.
    assign w_src_undef = !r_def[rec_a] || (w_op_two && !r_def[rec_b]);
    assign w_dst_bad   = (rec_dst < PI_LIMIT) || r_def[rec_dst];

    // Error classification, highest priority first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        w_code = CODE_OK;
        if (!(w_op_gate || w_op_end)) begin
            w_code = CODE_BADOP;
        end else if (w_src_undef) begin
            w_code = CODE_UNDEF;
        end else if (w_op_gate && w_dst_bad) begin
            w_code = CODE_BADDST;
        end
    end

    // Gate function applied to the current source values.
    always_comb begin
        w_gate_val = 1'b0;
        case (rec_op)
            OP_NOT:  w_gate_val = !r_val[rec_a];
            OP_AND:  w_gate_val = r_val[rec_a] & r_val[rec_b];
            OP_OR:   w_gate_val = r_val[rec_a] | r_val[rec_b];
            OP_BUF:  w_gate_val = r_val[rec_a];
            default: w_gate_val = 1'b0;
        endcase
    end

    // Next-state logic: start re-arms from any non-RUN state; RUN ends on END or error.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (w_accept) begin
                    if (w_code != CODE_OK) begin
                        w_next_state = S_ERR;
                    end else if (w_op_end) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    // Node storage, result, error code and gate counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the node arrays are flops, not RAM, so they can and do take the async reset.
            r_val        <= '0;
            r_def        <= '0;
            r_result     <= 1'b0;
            r_err_code   <= CODE_OK;
            r_gate_count <= '0;
        end else if (w_restart) begin
            r_def        <= PI_MASK;
            r_val        <= {{(MAX_NODES-PI_W){1'b0}}, pi_vec};
            r_result     <= 1'b0;
            r_err_code   <= CODE_OK;
            r_gate_count <= '0;
        end else if (w_accept) begin
            if (w_code != CODE_OK) begin
                r_err_code <= w_code;
            end else if (w_op_end) begin
                r_result <= r_val[rec_a];
            end else begin
                r_val[rec_dst] <= w_gate_val;
                r_def[rec_dst] <= 1'b1;
                if (r_gate_count != '1) begin
                    r_gate_count <= r_gate_count + CNT_W'(1);
                end
            end
        end
    end

    assign rec_ready  = (r_state == S_RUN);
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign result     = r_result;
    assign err_code   = r_err_code;
    assign gate_count = r_gate_count;

endmodule
